// File: rtl/prog_chain_ctrl.sv
// Bitstream loader for the tile programming scan chain: resets the chain, then shifts
// bit_count bits LSB-first from a valid/ready word stream. Optional readback CRC: PROG_CRC_EN.
module prog_chain_ctrl #(
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned LEN_W      = 20,
    parameter int unsigned RST_CYCLES = 4   // must be >= 1
) (
    input  logic              prog_clk,
    input  logic              prog_rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  bit_count,
    input  logic              wr_valid,
    input  logic [WORD_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              prog_rst,
    output logic              prog_we,
    output logic              prog_din,
    input  logic              prog_dout,
    input  logic              prog_we_o,
    output logic              prog_done,
    output logic              busy,
    output logic              error
`ifdef PROG_CRC_EN
    ,
    output logic [15:0]       crc
`endif
);

    localparam int unsigned NSH_W = $clog2(WORD_W + 1);
    localparam int unsigned RCW   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [NSH_W-1:0]  nshift_q, nshift_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [RCW-1:0]    rcnt_q, rcnt_d;
    logic              din_d;
    logic              error_d;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        nshift_d    = nshift_q;
        shreg_d     = shreg_q;
        rcnt_d      = rcnt_q;
        din_d       = 1'b0;
        error_d     = error;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (bit_count == '0) begin
                        error_d = 1'b1;
                    end else begin
                        error_d     = 1'b0;
                        remaining_d = bit_count;
                        rcnt_d      = RCW'(RST_CYCLES - 1);
                        state_d     = S_RST;
                    end
                end
            end
            S_RST: begin
                if (rcnt_q == '0) begin
                    state_d = S_LOAD;
                end else begin
                    rcnt_d = rcnt_q - RCW'(1);
                end
            end
            S_LOAD: begin
                if (wr_valid && wr_ready) begin
                    state_d = S_SHIFT;
                    din_d   = wr_data[0];
                    shreg_d = wr_data >> 1;
                    if (32'(remaining_q) >= WORD_W) begin
                        nshift_d = NSH_W'(WORD_W);
                    end else begin
                        nshift_d = NSH_W'(remaining_q);
                    end
                end
            end
            S_SHIFT: begin
                // prog_din already holds the current bit; shreg_q holds the bits still to come
                remaining_d = remaining_q - LEN_W'(1);
                nshift_d    = nshift_q - NSH_W'(1);
                if (remaining_q == LEN_W'(1)) begin
                    state_d = S_DONE;
                    shreg_d = '0;
                end else if (nshift_q == NSH_W'(1)) begin
                    state_d = S_LOAD;
                end else begin
                    din_d   = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            nshift_q    <= '0;
            shreg_q     <= '0;
            rcnt_q      <= '0;
            wr_ready    <= 1'b0;
            prog_rst    <= 1'b0;
            prog_we     <= 1'b0;
            prog_din    <= 1'b0;
            prog_done   <= 1'b0;
            busy        <= 1'b0;
            error       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            nshift_q    <= nshift_d;
            shreg_q     <= shreg_d;
            rcnt_q      <= rcnt_d;
            wr_ready    <= (state_d == S_LOAD);
            prog_rst    <= (state_d == S_RST);
            prog_we     <= (state_d == S_SHIFT);
            prog_din    <= din_d;
            prog_done   <= (state_d == S_DONE);
            busy        <= (state_d == S_RST) || (state_d == S_LOAD) || (state_d == S_SHIFT);
            error       <= error_d;
        end
    end

`ifdef PROG_CRC_EN
    logic [15:0] crc_q, crc_d;

    // Tail samples are taken only while loading/shifting, so the value freezes in DONE
    always_comb begin
        crc_d = crc_q;
        if (state_q == S_RST) begin
            crc_d = 16'hFFFF;
        end else if (((state_q == S_LOAD) || (state_q == S_SHIFT)) && prog_we_o) begin
            crc_d = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ prog_dout) ? 16'h1021 : 16'h0000);
        end
    end

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;
`else
    logic unused_tail;
    assign unused_tail = prog_dout ^ prog_we_o;
`endif

endmodule

// File: tb/tb_prog_chain_ctrl.sv
// Self-checking bench for prog_chain_ctrl: directed scenarios plus randomized runs
// compared against a bit-stream reference built from the word queue.
module tb_prog_chain_ctrl;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned LEN_W      = 20;
    localparam int unsigned RST_CYCLES = 4;

    logic              prog_clk   = 1'b0;
    logic              prog_rst_n = 1'b0;
    logic              start      = 1'b0;
    logic [LEN_W-1:0]  bit_count  = '0;
    logic              wr_valid   = 1'b0;
    logic [WORD_W-1:0] wr_data    = '0;
    logic              wr_ready, prog_rst, prog_we, prog_din, prog_done, busy, error;
    logic              prog_dout, prog_we_o;
`ifdef PROG_CRC_EN
    logic [15:0]       crc;
`endif

    assign prog_dout = prog_din;
    assign prog_we_o = prog_we;

    always #5 prog_clk = ~prog_clk;

    prog_chain_ctrl #(
        .WORD_W    (WORD_W),
        .LEN_W     (LEN_W),
        .RST_CYCLES(RST_CYCLES)
    ) dut (
        .prog_clk  (prog_clk),
        .prog_rst_n(prog_rst_n),
        .start     (start),
        .bit_count (bit_count),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .prog_rst  (prog_rst),
        .prog_we   (prog_we),
        .prog_din  (prog_din),
        .prog_dout (prog_dout),
        .prog_we_o (prog_we_o),
        .prog_done (prog_done),
        .busy      (busy),
        .error     (error)
`ifdef PROG_CRC_EN
        ,
        .crc       (crc)
`endif
    );

    int unsigned       n_checks = 0;
    int unsigned       n_fail   = 0;
    logic [WORD_W-1:0] words[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // CRC-16-CCITT, init 0xFFFF, bits fed in arrival order
    function automatic logic [15:0] crc_model(input bit b[$]);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        foreach (b[i]) begin
            fb = c[15] ^ b[i];
            c  = c << 1;
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    function automatic logic [6:0] outs();
        return {wr_ready, prog_rst, prog_we, prog_din, prog_done, busy, error};
    endfunction

    // One full programming sequence from IDLE/DONE using the global word queue.
    task automatic run_prog(input int unsigned n, input int unsigned gap, input bit gap_rand,
                            input bit noise, input string name);
        bit          exp_bits[$];
        bit          got[$];
        int unsigned nwords, idx, pending_gap, gap0, budget;
        int unsigned rst_cnt, bubbles, exp_bubbles, busy_bad, err_bad, ready_late, overlap;
        int          rst_first, rst_last, first_we, last_we, done_cyc;

        nwords = (n + WORD_W - 1) / WORD_W;
        idx = 0; rst_cnt = 0; bubbles = 0; exp_bubbles = 0;
        busy_bad = 0; err_bad = 0; ready_late = 0; overlap = 0;
        rst_first = -1; rst_last = -1; first_we = -1; last_we = -1; done_cyc = -1;
        for (int unsigned i = 0; i < n; i++) exp_bits.push_back(words[i / WORD_W][i % WORD_W]);
        pending_gap = gap_rand ? $urandom_range(0, gap) : gap;
        gap0 = pending_gap;
        budget = 2 * n + nwords * (gap + 2) + RST_CYCLES + 50;

        bit_count = LEN_W'(n);
        start     = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        for (int cyc = 0; cyc < int'(budget); cyc++) begin
            if (prog_rst) begin
                if (rst_first < 0) rst_first = cyc;
                rst_last = cyc;
                rst_cnt++;
            end
            if (prog_we) begin
                if (first_we < 0) first_we = cyc;
                last_we = cyc;
                got.push_back(prog_din);
            end else if (first_we >= 0 && !prog_done) begin
                bubbles++;
            end
            if (busy !== (prog_rst | wr_ready | prog_we)) busy_bad++;
            if (error !== 1'b0) err_bad++;
            if (wr_ready && prog_we) overlap++;
            if (wr_ready && idx >= nwords) ready_late++;
            if (prog_done) begin
                done_cyc = cyc;
                break;
            end
            start    = 1'b0;
            wr_valid = 1'b0;
            if (wr_ready && idx < nwords) begin
                if (pending_gap > 0) begin
                    pending_gap--;
                    if (idx > 0) exp_bubbles++;
                end else begin
                    wr_valid = 1'b1;
                    wr_data  = words[idx];
                    idx++;
                    if (idx > 1) exp_bubbles++;
                    pending_gap = gap_rand ? $urandom_range(0, gap) : gap;
                end
            end else begin
                wr_data = $urandom();
            end
            if (noise && prog_we && $urandom_range(0, 3) == 0) begin
                start     = 1'b1;
                bit_count = ($urandom_range(0, 1) == 0) ? '0 : LEN_W'($urandom());
            end
            @(negedge prog_clk);
        end
        start    = 1'b0;
        wr_valid = 1'b0;

        check_eq({name, ".done_seen"}, 64'(done_cyc >= 0), 64'd1);
        check_eq({name, ".rst_first"}, 64'(rst_first), 64'd0);
        check_eq({name, ".rst_cycles"}, 64'(rst_cnt), 64'(RST_CYCLES));
        check_eq({name, ".rst_last"}, 64'(rst_last), 64'(RST_CYCLES - 1));
        check_eq({name, ".first_we"}, 64'(first_we), 64'(RST_CYCLES + 1 + gap0));
        check_eq({name, ".we_pulses"}, 64'(got.size()), 64'(n));
        for (int unsigned i = 0; i < n; i++) begin
            check_eq($sformatf("%s.din[%0d]", name, i),
                     (i < got.size()) ? 64'(got[i]) : 64'hDEAD, 64'(exp_bits[i]));
        end
        check_eq({name, ".done_after_last"}, 64'(done_cyc), 64'(last_we + 1));
        check_eq({name, ".bubbles"}, 64'(bubbles), 64'(exp_bubbles));
        check_eq({name, ".words_taken"}, 64'(idx), 64'(nwords));
        check_eq({name, ".busy_bad"}, 64'(busy_bad), 64'd0);
        check_eq({name, ".error_bad"}, 64'(err_bad), 64'd0);
        check_eq({name, ".ready_we_overlap"}, 64'(overlap), 64'd0);
        check_eq({name, ".ready_late"}, 64'(ready_late), 64'd0);
`ifdef PROG_CRC_EN
        check_eq({name, ".crc"}, 64'(crc), 64'(crc_model(exp_bits)));
`endif
        repeat (3) @(negedge prog_clk);
        check_eq({name, ".done_hold"}, 64'(outs()), 64'b0000100);
`ifdef PROG_CRC_EN
        check_eq({name, ".crc_frozen"}, 64'(crc), 64'(crc_model(exp_bits)));
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned k;
        int unsigned n;

        // Power-on reset
        repeat (3) @(negedge prog_clk);
        check_eq("por.outputs", 64'(outs()), 64'd0);
`ifdef PROG_CRC_EN
        check_eq("por.crc", 64'(crc), 64'd0);
`endif
        prog_rst_n = 1'b1;
        @(negedge prog_clk);
        check_eq("idle.outputs", 64'(outs()), 64'd0);

        words = '{32'hA5A5_0F0F};
        run_prog(32, 0, 1'b0, 1'b0, "one_word");

        words = '{32'hFFFF_FFFF, 32'h0000_00AB};
        run_prog(40, 0, 1'b0, 1'b0, "two_words");

        // Zero-length start from DONE: flagged, no reset pulse, done kept
        bit_count = '0;
        start     = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        check_eq("zero_len.outputs", 64'(outs()), 64'b0000101);
        repeat (3) @(negedge prog_clk);
        check_eq("zero_len.sticky", 64'(outs()), 64'b0000101);

        words = '{32'h1234_5678};
        run_prog(8, 0, 1'b0, 1'b0, "after_error");

        words = '{};
        for (int i = 0; i < 3; i++) words.push_back($urandom());
        run_prog(80, 10, 1'b0, 1'b1, "stall");

        words = '{32'h0000_0031};
        run_prog(8, 0, 1'b0, 1'b0, "crc_byte");

        for (int r = 0; r < 12; r++) begin
            n = $urandom_range(1, 130);
            words = '{};
            for (int unsigned i = 0; i < (n + WORD_W - 1) / WORD_W; i++) words.push_back($urandom());
            run_prog(n, 4, 1'b1, 1'b1, $sformatf("rnd%0d", r));
        end

        // Asynchronous reset in the middle of shifting
        bit_count = LEN_W'(64);
        start     = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        k = 0;
        while (!prog_we && k < 50) begin
            wr_valid = wr_ready;
            wr_data  = '1;
            @(negedge prog_clk);
            k++;
        end
        wr_valid = 1'b0;
        check_eq("mid_rst.shifting", 64'(prog_we), 64'd1);
        repeat (3) @(negedge prog_clk);
        check_eq("mid_rst.din_high", 64'(prog_we & prog_din), 64'd1);
        #2 prog_rst_n = 1'b0;
        #1 check_eq("mid_rst.async_outputs", 64'(outs()), 64'd0);
        @(negedge prog_clk);
        check_eq("mid_rst.held_outputs", 64'(outs()), 64'd0);
        prog_rst_n = 1'b1;
        repeat (2) @(negedge prog_clk);
        check_eq("mid_rst.idle", 64'(outs()), 64'd0);

        // Zero-length start from IDLE
        bit_count = '0;
        start     = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        check_eq("idle_zero.outputs", 64'(outs()), 64'b0000001);

        words = '{32'hDEAD_BEEF};
        run_prog(20, 2, 1'b1, 1'b0, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
